// File: rtl/shift_chain_tapmux.sv
// Chain of DEPTH resettable WIDTH-bit stages with serial shift, parallel load,
// a fill-level tracker and a selectable tap whose valid flag follows the fill.
module shift_chain_tapmux #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8,
  parameter int SELW  = $clog2(DEPTH)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   EN,
  input  logic                   LOAD,
  input  logic [WIDTH-1:0]       D,
  input  logic [DEPTH*WIDTH-1:0] PD,
  input  logic [SELW-1:0]        SEL,
  output logic [WIDTH-1:0]       Q,
  output logic [WIDTH-1:0]       QS,
  output logic                   QV,
  output logic [SELW:0]          FILL,
  output logic                   FULL
);

  localparam logic [SELW:0] DEPTH_C = (SELW + 1)'(DEPTH);
  localparam logic [SELW:0] ONE_C   = (SELW + 1)'(1);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [SELW:0]    fill_q;
  logic [SELW:0]    fill_d;

  // Next-state: LOAD takes precedence over EN; RESET is applied in the flop block.
  always_comb begin
    stage_d = stage_q;
    fill_d  = fill_q;
    if (LOAD) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_d[i] = PD[i*WIDTH +: WIDTH];
      end
      fill_d = DEPTH_C;
    end else if (EN) begin
      stage_d[0] = D;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
      // Fill saturates at DEPTH rather than wrapping.
      if (fill_q != DEPTH_C) begin
        fill_d = fill_q + ONE_C;
      end else begin
        fill_d = fill_q;
      end
    end else begin
      stage_d = stage_q;
      fill_d  = fill_q;
    end
  end

  // Stage and fill registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
      fill_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
      fill_q <= fill_d;
    end
  end

  // Tap mux: selects outside the chain (non-power-of-2 DEPTH) read as zero.
  always_comb begin
    Q = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (SEL == SELW'(i)) begin
        Q = stage_q[i];
      end else begin
        Q = Q;
      end
    end
  end

  // FILL never exceeds DEPTH, so this also forces QV low for SEL >= DEPTH.
  assign QV   = ({1'b0, SEL} < fill_q);
  assign QS   = stage_q[DEPTH-1];
  assign FILL = fill_q;
  assign FULL = (fill_q == DEPTH_C);

endmodule
